// File: rtl/awgn_mem_pkg.sv
// Shared sizing and controller state encoding for the AWGN noise-table reader.
package awgn_mem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 52;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_e;

endpackage

// File: rtl/awgn_rsp_fifo.sv
// Two-entry response FIFO; head word is held stable until it is popped.
module awgn_rsp_fifo #(
  parameter int WIDTH = awgn_mem_pkg::ADDR_W + awgn_mem_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) slot_q[wr_ptr_q] <= in_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/awgn_table_reader.sv
// Loads the AWGN noise table into an external synchronous RAM, then serves
// pipelined lookups through a two-entry response FIFO.
//
// state | meaning
// IDLE  | table invalid, waiting for ld_start
// LOAD  | accepting load words into ascending addresses
// SERVE | table valid, lookups accepted
module awgn_table_reader #(
  parameter int ADDR_W = awgn_mem_pkg::ADDR_W,
  parameter int DATA_W = awgn_mem_pkg::DATA_W,
  parameter int DEPTH  = awgn_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_done,
  output logic              table_ok,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_idx,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_idx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import awgn_mem_pkg::state_e;
  import awgn_mem_pkg::IDLE;
  import awgn_mem_pkg::LOAD;
  import awgn_mem_pkg::SERVE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              table_ok_q, table_ok_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              infl_q;
  logic [ADDR_W-1:0] rd_idx_q;

  logic              ld_hs, req_hs, last_word;
  logic              fifo_in_ready, fifo_out_valid;
  logic [2:0]        occ, pop_cnt;

  assign ld_hs     = (state_q == LOAD) && ld_valid;
  assign last_word = (ptr_q == ADDR_W'(DEPTH - 1));
  assign req_hs    = req_valid && req_ready;

  // FIFO count recovered from its flags: 2 when full, 1 when holding, 0 when empty.
  assign occ     = {2'b00, fifo_out_valid} + {2'b00, ~fifo_in_ready} + {2'b00, infl_q};
  assign pop_cnt = {2'b00, rsp_valid && rsp_ready};

  assign req_ready = (state_q == SERVE) && ((occ - pop_cnt) < 3'd2);
  assign ld_ready  = (state_q == LOAD);
  assign ld_done   = ld_hs && last_word;
  assign table_ok  = table_ok_q;

  assign mem_we    = ld_hs;
  assign mem_wdata = ld_hs ? ld_data : '0;
  assign mem_addr  = ld_hs  ? ptr_q   :
                     req_hs ? req_idx : mem_addr_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    table_ok_d = table_ok_q;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (ld_hs) begin
          if (last_word) begin
            state_d    = SERVE;
            ptr_d      = '0;
            table_ok_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      SERVE: begin
        // A reload must not overtake lookups still owed to the requester.
        if (ld_start && !infl_q && !fifo_out_valid) begin
          state_d    = LOAD;
          ptr_d      = '0;
          table_ok_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        ptr_d      = '0;
        table_ok_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      table_ok_q <= 1'b0;
      mem_addr_q <= '0;
      infl_q     <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      table_ok_q <= table_ok_d;
      mem_addr_q <= mem_addr;
      infl_q     <= req_hs;
      if (req_hs) rd_idx_q <= req_idx;
    end
  end

  awgn_rsp_fifo #(
    .WIDTH (ADDR_W + DATA_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (infl_q),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   ({rd_idx_q, mem_rdata}),
    .out_valid_o (fifo_out_valid),
    .out_ready_i (rsp_ready),
    .out_data_o  ({rsp_idx, rsp_data})
  );

  assign rsp_valid = fifo_out_valid;

endmodule
